// File: rtl/regfile_pkg.sv
// Shared register-file constants and helpers for the datapath and decode.
// Combinational helpers only; no latency and no flow control.
package regfile_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 32;
   localparam int REG_ZERO  = 0;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: reserves destinations at issue, releases them at writeback.
// iss_ready is combinational; pend and npend update at the next edge; a refused issue must be held.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int ADDRW = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_iss_en,
   input  logic [ADDRW-1:0] i_iss_wa,
   input  logic             i_clr_en,
   input  logic [ADDRW-1:0] i_clr_addr,
   input  logic             i_flush,
   output logic             o_iss_ready,
   output logic [DEPTH-1:0] o_pend,
   output logic [ADDRW:0]   o_npend
);

   logic [DEPTH-1:0] r_pend;
   logic [ADDRW:0]   r_npend;
   logic [DEPTH-1:0] w_pend_nxt;
   logic [ADDRW:0]   w_cnt;
   logic             w_iss_ready;
   logic             w_accept;

   always_comb begin
      // A writeback to the same register in this cycle frees the slot for the new issue.
      w_iss_ready = (i_iss_wa == ADDRW'(REG_ZERO)) | ~r_pend[i_iss_wa]
                  | (i_clr_en & (i_clr_addr == i_iss_wa));
      w_accept    = i_iss_en & w_iss_ready & ~i_flush & (i_iss_wa != ADDRW'(REG_ZERO));

      w_pend_nxt = r_pend;
      if (i_clr_en) begin
         w_pend_nxt[i_clr_addr] = 1'b0;
      end
      if (w_accept) begin
         w_pend_nxt[i_iss_wa] = 1'b1;
      end
      if (i_flush) begin
         w_pend_nxt = '0;
      end
      w_pend_nxt[REG_ZERO] = 1'b0;

      w_cnt = '0;
      for (int i = 1; i < DEPTH; i++) begin
         w_cnt = w_cnt + {{ADDRW{1'b0}}, w_pend_nxt[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend  <= '0;
         r_npend <= '0;
      end else begin
         r_pend  <= w_pend_nxt;
         r_npend <= w_cnt;
      end
   end

   assign o_iss_ready = w_iss_ready;
   assign o_pend      = r_pend;
   assign o_npend     = r_npend;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with pending-write scoreboard and optional write-to-read bypass.
// Reads are zero-latency, writes land at the edge; issue backpressure is iss_ready, caller holds.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int NREAD  = 2,
   parameter int BYPASS = 1,
   localparam int ADDRW = clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREAD*ADDRW-1:0] ra,
   output logic [NREAD*WIDTH-1:0] rd,
   output logic [NREAD-1:0]       rbusy,
   input  logic                   we,
   input  logic [ADDRW-1:0]       wa,
   input  logic [WIDTH-1:0]       wd,
   input  logic                   iss_en,
   input  logic [ADDRW-1:0]       iss_wa,
   output logic                   iss_ready,
   input  logic                   flush,
   output logic [ADDRW:0]         npend
);

   logic [WIDTH-1:0] r_rf [DEPTH];
   logic [DEPTH-1:0] w_pend;
   logic [ADDRW-1:0] w_a;
   logic             w_wr;

   assign w_wr = we & (wa != ADDRW'(REG_ZERO));

   regfile_scoreboard #(
      .DEPTH (DEPTH),
      .ADDRW (ADDRW)
   ) u_sb (
      .clk         (clk),
      .reset       (reset),
      .i_iss_en    (iss_en),
      .i_iss_wa    (iss_wa),
      .i_clr_en    (we),
      .i_clr_addr  (wa),
      .i_flush     (flush),
      .o_iss_ready (iss_ready),
      .o_pend      (w_pend),
      .o_npend     (npend)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_rf[i] <= '0;
         end
      end else if (w_wr) begin
         r_rf[wa] <= wd;
      end
   end

   always_comb begin
      rd    = '0;
      rbusy = '0;
      w_a   = '0;
      for (int p = 0; p < NREAD; p++) begin
         w_a = ra[p*ADDRW +: ADDRW];
         // Register 0 reads as zero and is never busy, regardless of array contents.
         if (w_a != ADDRW'(REG_ZERO)) begin
            if ((BYPASS != 0) && we && (wa == w_a)) begin
               rd[p*WIDTH +: WIDTH] = wd;
            end else begin
               rd[p*WIDTH +: WIDTH] = r_rf[w_a];
               rbusy[p]             = w_pend[w_a];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, a stall sequence, then random traffic vs a reference model.
module tb_regfile_sb;

   localparam int W  = 32;
   localparam int D  = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic              clk;
   logic              reset;
   logic [NR*AW-1:0]  ra;
   logic [NR*W-1:0]   rd, rd_nb;
   logic [NR-1:0]     rbusy, rbusy_nb;
   logic              we;
   logic [AW-1:0]     wa;
   logic [W-1:0]      wd;
   logic              iss_en;
   logic [AW-1:0]     iss_wa;
   logic              iss_ready, iss_ready_nb;
   logic              flush;
   logic [AW:0]       npend, npend_nb;

   regfile_sb #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .BYPASS(1)) u_dut (
      .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
      .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_wa(iss_wa),
      .iss_ready(iss_ready), .flush(flush), .npend(npend)
   );

   regfile_sb #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .BYPASS(0)) u_nb (
      .clk(clk), .reset(reset), .ra(ra), .rd(rd_nb), .rbusy(rbusy_nb),
      .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_wa(iss_wa),
      .iss_ready(iss_ready_nb), .flush(flush), .npend(npend_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference state: architectural register contents and reservation set.
   logic [W-1:0] m_rf [D];
   bit           m_pend [D];

   typedef struct {
      logic          rst, we;
      logic [AW-1:0] wa;
      logic [W-1:0]  wd;
      logic          ie;
      logic [AW-1:0] iwa;
      logic          fl;
      logic [AW-1:0] ra0, ra1;
      logic [W-1:0]  e_rd0, e_rd1;
      logic          e_b0, e_b1, e_rdy;
      logic [AW:0]   e_np;
      logic          chk_nb;
      logic [W-1:0]  e_nb1;
   } vec_t;

   vec_t tbl [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, input logic we_i, input int wa_i, input logic [31:0] wd_i,
                               input logic ie, input int iwa, input logic fl, input int ra0, input int ra1,
                               input logic [31:0] e0, input logic [31:0] e1, input logic b0, input logic b1,
                               input logic rdy, input int np, input logic cnb, input logic [31:0] enb);
      vec_t v;
      v.rst = rst; v.we = we_i; v.wa = AW'(wa_i); v.wd = wd_i;
      v.ie = ie; v.iwa = AW'(iwa); v.fl = fl;
      v.ra0 = AW'(ra0); v.ra1 = AW'(ra1);
      v.e_rd0 = e0; v.e_rd1 = e1; v.e_b0 = b0; v.e_b1 = b1; v.e_rdy = rdy;
      v.e_np = (AW+1)'(np); v.chk_nb = cnb; v.e_nb1 = enb;
      return v;
   endfunction

   task automatic drive(input logic r, input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic ie, input logic [AW-1:0] ia, input logic f,
                        input logic [AW-1:0] r0, input logic [AW-1:0] r1);
      reset = r; we = w; wa = a; wd = d; iss_en = ie; iss_wa = ia; flush = f;
      ra = {r1, r0};
   endtask

   function automatic int m_count();
      int n;
      n = 0;
      for (int i = 0; i < D; i++) n += int'(m_pend[i]);
      return n;
   endfunction

   // Apply the architectural rules for the edge that has just occurred.
   task automatic model_edge();
      bit rdy;
      if (reset) begin
         for (int i = 0; i < D; i++) begin
            m_rf[i] = '0;
            m_pend[i] = 1'b0;
         end
      end else begin
         rdy = (iss_wa == 0) || !m_pend[iss_wa] || (we && wa == iss_wa);
         if (we && wa != 0) begin
            m_rf[wa] = wd;
            m_pend[wa] = 1'b0;
         end
         if (flush) begin
            for (int i = 0; i < D; i++) m_pend[i] = 1'b0;
         end else if (iss_en && rdy && iss_wa != 0) begin
            m_pend[iss_wa] = 1'b1;
         end
      end
   endtask

   task automatic check_model_comb();
      logic [AW-1:0] a;
      logic [W-1:0]  e_rd, e_nb;
      logic          e_b, e_bnb, e_rdy;
      for (int p = 0; p < NR; p++) begin
         a = ra[p*AW +: AW];
         if (a == 0) begin
            e_rd = '0; e_b = 1'b0; e_nb = '0; e_bnb = 1'b0;
         end else begin
            e_nb = m_rf[a]; e_bnb = m_pend[a];
            if (we && wa == a) begin
               e_rd = wd; e_b = 1'b0;
            end else begin
               e_rd = m_rf[a]; e_b = m_pend[a];
            end
         end
         chk($sformatf("rnd_rd%0d", p), rd[p*W +: W], e_rd);
         chk($sformatf("rnd_busy%0d", p), 32'(rbusy[p]), 32'(e_b));
         chk($sformatf("rnd_nb_rd%0d", p), rd_nb[p*W +: W], e_nb);
         chk($sformatf("rnd_nb_busy%0d", p), 32'(rbusy_nb[p]), 32'(e_bnb));
      end
      e_rdy = (iss_wa == 0) || !m_pend[iss_wa] || (we && wa == iss_wa);
      chk("rnd_iss_ready", 32'(iss_ready), 32'(e_rdy));
   endtask

   initial begin
      for (int i = 0; i < D; i++) begin
         m_rf[i] = '0;
         m_pend[i] = 1'b0;
      end
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) begin
         @(posedge clk);
         model_edge();
      end
      #1;

      tbl.push_back(mk(0,0,0,32'h0,       0,0,0, 5,0, 32'h0,32'h0,0,0,1, 0, 0,32'h0));
      tbl.push_back(mk(0,1,0,32'hDEADBEEF,0,0,0, 0,0, 32'h0,32'h0,0,0,1, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       0,0,0, 0,5, 32'h0,32'h0,0,0,1, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       1,7,0, 7,0, 32'h0,32'h0,0,0,1, 1, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       1,7,0, 7,7, 32'h0,32'h0,1,1,0, 1, 0,32'h0));
      tbl.push_back(mk(0,1,7,32'h12345678,0,7,0, 7,0, 32'h12345678,32'h0,0,0,1, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       0,0,0, 7,0, 32'h12345678,32'h0,0,0,1, 0, 0,32'h0));
      tbl.push_back(mk(0,1,3,32'h11110000,0,0,0, 3,7, 32'h11110000,32'h12345678,0,0,1, 0, 0,32'h0));
      tbl.push_back(mk(0,1,3,32'hA5A5A5A5,0,0,0, 7,3, 32'h12345678,32'hA5A5A5A5,0,0,1, 0, 1,32'h11110000));
      tbl.push_back(mk(0,0,0,32'h0,       1,9,0, 9,3, 32'h0,32'hA5A5A5A5,0,0,1, 1, 0,32'h0));
      tbl.push_back(mk(0,1,9,32'h99,      1,9,0, 9,0, 32'h99,32'h0,0,0,1, 1, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       0,0,0, 9,9, 32'h99,32'h99,1,1,1, 1, 0,32'h0));
      tbl.push_back(mk(0,1,9,32'h9A,      0,0,0, 0,0, 32'h0,32'h0,0,0,1, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       1,1,0, 1,0, 32'h0,32'h0,0,0,1, 1, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       1,2,0, 1,2, 32'h0,32'h0,1,0,1, 2, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       1,4,0, 1,2, 32'h0,32'h0,1,1,1, 3, 0,32'h0));
      tbl.push_back(mk(0,1,2,32'h55,      1,6,1, 2,6, 32'h55,32'h0,0,0,1, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       0,0,0, 2,6, 32'h55,32'h0,0,0,1, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       0,0,0, 1,4, 32'h0,32'h0,0,0,1, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       1,1,0, 7,2, 32'h12345678,32'h55,0,0,1, 1, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       1,2,0, 1,0, 32'h0,32'h0,1,0,1, 2, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       1,3,0, 3,2, 32'hA5A5A5A5,32'h55,0,1,1, 3, 0,32'h0));
      tbl.push_back(mk(1,1,5,32'hFFFF,    1,8,0, 7,2, 32'h12345678,32'h55,0,1,1, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       0,0,0, 7,2, 32'h0,32'h0,0,0,1, 0, 0,32'h0));
      tbl.push_back(mk(0,0,0,32'h0,       0,0,0, 5,8, 32'h0,32'h0,0,0,1, 0, 0,32'h0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ie, tbl[i].iwa, tbl[i].fl,
               tbl[i].ra0, tbl[i].ra1);
         #1;
         chk($sformatf("v%0d_rd0", i), rd[0 +: W], tbl[i].e_rd0);
         chk($sformatf("v%0d_rd1", i), rd[W +: W], tbl[i].e_rd1);
         chk($sformatf("v%0d_busy0", i), 32'(rbusy[0]), 32'(tbl[i].e_b0));
         chk($sformatf("v%0d_busy1", i), 32'(rbusy[1]), 32'(tbl[i].e_b1));
         chk($sformatf("v%0d_iss_ready", i), 32'(iss_ready), 32'(tbl[i].e_rdy));
         if (tbl[i].chk_nb) chk($sformatf("v%0d_nb_rd1", i), rd_nb[W +: W], tbl[i].e_nb1);
         @(posedge clk);
         model_edge();
         #1;
         chk($sformatf("v%0d_npend", i), 32'(npend), 32'(tbl[i].e_np));
      end

      // Refused issue held across several cycles, then accepted alongside its writeback.
      drive(0, 0, 0, 0, 1, 10, 0, 10, 0);
      @(posedge clk); model_edge(); #1;
      chk("stall_npend0", 32'(npend), 32'd1);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 0, 1, 10, 0, 10, 0);
         #1;
         chk("stall_ready", 32'(iss_ready), 32'd0);
         @(posedge clk); model_edge(); #1;
         chk("stall_npend", 32'(npend), 32'd1);
      end
      drive(0, 1, 10, 32'hCAFE, 1, 10, 0, 0, 0);
      #1;
      chk("stall_release_ready", 32'(iss_ready), 32'd1);
      @(posedge clk); model_edge(); #1;
      chk("stall_release_npend", 32'(npend), 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 10, 10);
      #1;
      chk("stall_rd", rd[0 +: W], 32'hCAFE);
      chk("stall_busy", 32'(rbusy[0]), 32'd1);

      for (int n = 0; n < 400; n++) begin
         logic [AW-1:0] a0, a1, w_a, i_a;
         a0  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         a1  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         w_a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         i_a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         drive(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), w_a, $urandom,
               1'($urandom_range(0, 1)), i_a, ($urandom_range(0, 19) == 0), a0, a1);
         #1;
         check_model_comb();
         @(posedge clk);
         model_edge();
         #1;
         chk("rnd_npend", 32'(npend), 32'(m_count()));
         chk("rnd_nb_npend", 32'(npend_nb), 32'(m_count()));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
